// File: rtl/dma_desc_pkg.sv
// Shared types for the DMA descriptor engine: FSM states, descriptor field offsets, width helpers.
package dma_desc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SIZE,
        REQ,
        WAIT_ACK
    } state_e;

    // Descriptor word layout is {count, addr}; count starts right above addr.
    localparam int ADDR_LSB = 0;

    function automatic int cnt_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping to 0.
// Zero latency; no state, the pointer register lives in the caller.
module dma_rr_arbiter
    import dma_desc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              vld_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        vld_o   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!vld_o && req_i[i] && (i >= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                idx_o      = CH_W'(i);
                vld_o      = 1'b1;
            end
        end
        // Wrapped pass only runs when nothing at or above the pointer asked.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!vld_o && req_i[i] && (i < int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                idx_o      = CH_W'(i);
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_desc_engine.sv
// Round-robin descriptor engine: splits each descriptor into <=MAX_BURST bursts, issued only when fifo_room fits.
// desc_rden->fetch_req is 4 cycles; fetch_req holds until fetch_ack. DMA_DESC_BOUNDARY_SPLIT_EN adds boundary clipping.
module dma_desc_engine
    import dma_desc_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 32,
    parameter int BURST_W         = 8,
    parameter int MAX_BURST       = 8,
    parameter int WORD_BYTES_LOG2 = 2,
    parameter int CH_W            = ch_width(NUM_CH)
`ifdef DMA_DESC_BOUNDARY_SPLIT_EN
    ,
    parameter int BOUNDARY_LOG2   = 12
`endif
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic [NUM_CH-1:0]                desc_valid,
    input  logic [NUM_CH*(CNT_W+ADDR_W)-1:0] desc_data,
    output logic [NUM_CH-1:0]                desc_rden,
    output logic                             fetch_req,
    output logic [ADDR_W-1:0]                fetch_addr,
    output logic [BURST_W-1:0]               fetch_len,
    output logic [CH_W-1:0]                  fetch_ch,
    input  logic                             fetch_ack,
    input  logic [BURST_W-1:0]               fifo_room,
    output logic                             room_take,
    output logic [NUM_CH-1:0]                desc_done,
    output logic                             busy
);

    localparam int DW      = CNT_W + ADDR_W;
    localparam int CNT_LSB = cnt_lsb(ADDR_W);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [BURST_W-1:0]  len_q, len_d;
    logic                req_q, req_d;
    logic                take_q, take_d;
    logic [NUM_CH-1:0]   done_q, done_d;

    logic [NUM_CH-1:0]   gnt;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [BURST_W-1:0]  burst_len;
    logic [DW-1:0]       desc_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_desc
        assign desc_arr[i] = desc_data[i*DW +: DW];
    end

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i   (desc_valid),
        .ptr_i   (rr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .vld_o   (gnt_vld)
    );

`ifdef DMA_DESC_BOUNDARY_SPLIT_EN
    logic [BOUNDARY_LOG2:0] bnd_bytes;
`endif

    always_comb begin
        burst_len = (remain_q < CNT_W'(MAX_BURST)) ? remain_q[BURST_W-1:0] : BURST_W'(MAX_BURST);
`ifdef DMA_DESC_BOUNDARY_SPLIT_EN
        // Bytes left before the next 2^BOUNDARY_LOG2 boundary, converted to words.
        bnd_bytes = {1'b1, {BOUNDARY_LOG2{1'b0}}} - {1'b0, addr_q[BOUNDARY_LOG2-1:0]};
        if (int'(bnd_bytes >> WORD_BYTES_LOG2) < int'(burst_len)) begin
            burst_len = BURST_W'(bnd_bytes >> WORD_BYTES_LOG2);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        len_d     = len_q;
        req_d     = req_q;
        take_d    = 1'b0;
        done_d    = '0;
        desc_rden = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    desc_rden = gnt;
                    ch_d      = gnt_idx;
                    rr_d      = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                addr_d   = desc_arr[ch_q][ADDR_LSB +: ADDR_W];
                remain_d = desc_arr[ch_q][CNT_LSB +: CNT_W];
                if (desc_arr[ch_q][CNT_LSB +: CNT_W] == '0) begin
                    done_d  = NUM_CH'(1) << ch_q;
                    state_d = IDLE;
                end else begin
                    state_d = SIZE;
                end
            end
            SIZE: begin
                len_d   = burst_len;
                state_d = REQ;
            end
            REQ: begin
                if (fifo_room >= len_q) begin
                    req_d    = 1'b1;
                    take_d   = 1'b1;
                    remain_d = remain_q - CNT_W'(len_q);
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (fetch_ack) begin
                    req_d = 1'b0;
                    if (remain_q == '0) begin
                        done_d  = NUM_CH'(1) << ch_q;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + (ADDR_W'(len_q) << WORD_BYTES_LOG2);
                        state_d = SIZE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            len_q    <= '0;
            req_q    <= 1'b0;
            take_q   <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            len_q    <= len_d;
            req_q    <= req_d;
            take_q   <= take_d;
            done_q   <= done_d;
        end
    end

    assign fetch_req  = req_q;
    assign fetch_addr = addr_q;
    assign fetch_len  = len_q;
    assign fetch_ch   = ch_q;
    assign room_take  = take_q;
    assign desc_done  = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dma_desc_engine.sv
// Directed bench for dma_desc_engine: descriptor FIFO model, auto-ack fetch unit, burst log.
module tb_dma_desc_engine;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;
    localparam int CH_W    = 2;
    localparam int DW      = CNT_W + ADDR_W;

    logic                   clk = 1'b0;
    logic                   rstb;
    logic [NUM_CH-1:0]      desc_valid;
    logic [NUM_CH*DW-1:0]   desc_data;
    logic [NUM_CH-1:0]      desc_rden;
    logic                   fetch_req;
    logic [ADDR_W-1:0]      fetch_addr;
    logic [BURST_W-1:0]     fetch_len;
    logic [CH_W-1:0]        fetch_ch;
    logic                   fetch_ack;
    logic [BURST_W-1:0]     fifo_room;
    logic                   room_take;
    logic [NUM_CH-1:0]      desc_done;
    logic                   busy;

    always #5 clk = ~clk;

    dma_desc_engine dut (
        .clk        (clk),
        .rstb       (rstb),
        .desc_valid (desc_valid),
        .desc_data  (desc_data),
        .desc_rden  (desc_rden),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_len  (fetch_len),
        .fetch_ch   (fetch_ch),
        .fetch_ack  (fetch_ack),
        .fifo_room  (fifo_room),
        .room_take  (room_take),
        .desc_done  (desc_done),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    int cnum;
    int pending  [NUM_CH];
    int rden_cnt [NUM_CH];
    int rden_cyc [NUM_CH];
    int done_cnt [NUM_CH];
    int done_cyc [NUM_CH];
    int take_cnt;
    int nb;
    logic [ADDR_W-1:0]  b_addr [16];
    logic [BURST_W-1:0] b_len  [16];
    logic [CH_W-1:0]    b_ch   [16];
    int                 b_cyc  [16];
    int stab_err;
    int req_age;
    int ack_delay;
    bit stray;
    logic prev_req;
    logic [ADDR_W+BURST_W+CH_W-1:0] prev_f;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int c = 0; c < NUM_CH; c++) begin
            rden_cnt[c] = 0; rden_cyc[c] = -1; done_cnt[c] = 0; done_cyc[c] = -1;
        end
        take_cnt = 0; nb = 0; stab_err = 0; req_age = 0; prev_req = 1'b0; prev_f = '0;
        for (int k = 0; k < 16; k++) begin
            b_addr[k] = '0; b_len[k] = '0; b_ch[k] = '0; b_cyc[k] = -1;
        end
    endtask

    task automatic push(input int c, input int n, input logic [CNT_W-1:0] cnt, input logic [ADDR_W-1:0] addr);
        desc_data[c*DW +: DW] = {cnt, addr};
        pending[c] += n;
        desc_valid[c] = 1'b1;
    endtask

    // One clock: consume the read issued this cycle, advance, then log and drive the fetch unit.
    task automatic cyc();
        logic [NUM_CH-1:0] rd;
        #1;
        rd = desc_rden;
        @(posedge clk);
        #1;
        cnum++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd[c]) begin
                rden_cnt[c]++;
                rden_cyc[c] = cnum - 1;
                if (pending[c] > 0) pending[c]--;
            end
            desc_valid[c] = (pending[c] > 0);
            if (desc_done[c]) begin
                done_cnt[c]++;
                done_cyc[c] = cnum;
            end
        end
        if (room_take) take_cnt++;
        if (fetch_req && !prev_req) begin
            if (nb < 16) begin
                b_addr[nb] = fetch_addr; b_len[nb] = fetch_len; b_ch[nb] = fetch_ch; b_cyc[nb] = cnum;
            end
            nb++;
            req_age = 0;
        end
        if (fetch_req && prev_req && ({fetch_addr, fetch_len, fetch_ch} != prev_f)) stab_err++;
        if (fetch_req) req_age++;
        prev_req = fetch_req;
        prev_f   = {fetch_addr, fetch_len, fetch_ch};
        fetch_ack = fetch_req ? (req_age > ack_delay) : (stray && busy);
    endtask

    task automatic run(input string tag, input int maxc);
        int k;
        int left;
        for (k = 0; k < maxc; k++) begin
            cyc();
            left = 0;
            for (int c = 0; c < NUM_CH; c++) left += pending[c];
            if (k > 1 && !busy && !fetch_req && left == 0) break;
        end
        check({tag, "_finished"}, 64'(k < maxc), 64'd1);
    endtask

    initial begin
        int k;
        rstb = 1'b0; desc_valid = '0; desc_data = '0; fetch_ack = 1'b0; fifo_room = 8'd255;
        cnum = 0; ack_delay = 0; stray = 1'b0;
        for (int c = 0; c < NUM_CH; c++) pending[c] = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        #1;
        check("rst_fetch_req", 64'(fetch_req), 64'd0);
        check("rst_room_take", 64'(room_take), 64'd0);
        check("rst_desc_done", 64'(desc_done), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_fetch_len", 64'(fetch_len), 64'd0);

        // Round robin with ch0 and ch2 both backlogged; pointer starts at 0.
        push(0, 2, 32'd4, 32'h100);
        push(2, 2, 32'd4, 32'h300);
        run("rr", 200);
        check("rr_nbursts", 64'(nb), 64'd4);
        check("rr_ch0", 64'(b_ch[0]), 64'd0);
        check("rr_ch1", 64'(b_ch[1]), 64'd2);
        check("rr_ch2", 64'(b_ch[2]), 64'd0);
        check("rr_ch3", 64'(b_ch[3]), 64'd2);
        check("rr_addr1", 64'(b_addr[1]), 64'h300);
        check("rr_len0", 64'(b_len[0]), 64'd4);
        check("rr_rden1", 64'(rden_cnt[1]), 64'd0);
        check("rr_rden3", 64'(rden_cnt[3]), 64'd0);
        check("rr_done0", 64'(done_cnt[0]), 64'd2);
        check("rr_done2", 64'(done_cnt[2]), 64'd2);

        // 20 words from 0x1000 split into 8+8+4.
        clear_mon();
        push(0, 1, 32'd20, 32'h1000);
        run("split", 200);
        check("split_nbursts", 64'(nb), 64'd3);
        check("split_b0", {b_addr[0], 24'd0, b_len[0]}, {32'h1000, 24'd0, 8'd8});
        check("split_b1", {b_addr[1], 24'd0, b_len[1]}, {32'h1020, 24'd0, 8'd8});
        check("split_b2", {b_addr[2], 24'd0, b_len[2]}, {32'h1040, 24'd0, 8'd4});
        check("split_take", 64'(take_cnt), 64'd3);
        check("split_done", 64'(done_cnt[0]), 64'd1);
        check("split_latency", 64'(b_cyc[0] - rden_cyc[0]), 64'd4);
        check("split_b2b", 64'(b_cyc[1] - b_cyc[0]), 64'd3);
        check("split_done_cyc", 64'(done_cyc[0] - b_cyc[2]), 64'd1);

        // Zero-count descriptor completes without a fetch.
        clear_mon();
        push(1, 1, 32'd0, 32'h2222);
        run("zero", 50);
        check("zero_rden", 64'(rden_cnt[1]), 64'd1);
        check("zero_done", 64'(done_cnt[1]), 64'd1);
        check("zero_done_cyc", 64'(done_cyc[1] - rden_cyc[1]), 64'd2);
        check("zero_nbursts", 64'(nb), 64'd0);

        // Room stall: 5 words free is short of 8; exactly 8 passes.
        clear_mon();
        fifo_room = 8'd5;
        push(0, 1, 32'd8, 32'h2000);
        for (int i = 0; i < 12; i++) cyc();
        check("stall_no_req", 64'(nb), 64'd0);
        check("stall_no_take", 64'(take_cnt), 64'd0);
        fifo_room = 8'd8;
        k = cnum;
        run("stall", 50);
        check("stall_req_cyc", 64'(b_cyc[0] - k), 64'd1);
        check("stall_len", 64'(b_len[0]), 64'd8);
        check("stall_addr", 64'(b_addr[0]), 64'h2000);
        fifo_room = 8'd255;

        // Slow ack with stray acks whenever fetch_req is low.
        clear_mon();
        ack_delay = 5;
        stray = 1'b1;
        push(3, 1, 32'd16, 32'h4000);
        run("slow", 200);
        check("slow_nbursts", 64'(nb), 64'd2);
        check("slow_b0", {b_addr[0], 22'd0, b_ch[0], b_len[0]}, {32'h4000, 22'd0, 2'd3, 8'd8});
        check("slow_b1", {b_addr[1], 22'd0, b_ch[1], b_len[1]}, {32'h4020, 22'd0, 2'd3, 8'd8});
        check("slow_stable", 64'(stab_err), 64'd0);
        check("slow_take", 64'(take_cnt), 64'd2);
        check("slow_gap", 64'(b_cyc[1] - b_cyc[0]), 64'd8);
        check("slow_done", 64'(done_cnt[3]), 64'd1);
        stray = 1'b0;
        ack_delay = 0;

`ifdef DMA_DESC_BOUNDARY_SPLIT_EN
        // 0xFF8 has 8 bytes (2 words) before the 4 KiB line.
        clear_mon();
        push(0, 1, 32'd8, 32'h0FF8);
        run("bnd", 100);
        check("bnd_nbursts", 64'(nb), 64'd2);
        check("bnd_b0", {b_addr[0], 24'd0, b_len[0]}, {32'h0FF8, 24'd0, 8'd2});
        check("bnd_b1", {b_addr[1], 24'd0, b_len[1]}, {32'h1000, 24'd0, 8'd6});
`endif

        // Reset while waiting for ack drops the descriptor silently.
        clear_mon();
        ack_delay = 1000;
        push(0, 1, 32'd8, 32'h5000);
        for (k = 0; k < 20 && !fetch_req; k++) cyc();
        check("rstwait_req_seen", 64'(fetch_req), 64'd1);
        rstb = 1'b0;
        fetch_ack = 1'b0;
        #1;
        check("rstwait_fetch_req",  64'(fetch_req),  64'd0);
        check("rstwait_room_take",  64'(room_take),  64'd0);
        check("rstwait_busy",       64'(busy),       64'd0);
        check("rstwait_fetch_addr", 64'(fetch_addr), 64'd0);
        check("rstwait_desc_done",  64'(desc_done),  64'd0);
        @(posedge clk);
        #1 rstb = 1'b1;
        ack_delay = 0;
        clear_mon();
        for (int i = 0; i < 6; i++) cyc();
        check("rstwait_no_done", 64'(done_cnt[0]), 64'd0);
        check("rstwait_no_burst", 64'(nb), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
